// File: rtl/bsg_sync_gray_rx.sv
// bsg_sync_gray_rx: Gray pointer synchronizer with binary decode, valid/yumi delta and Gray-discipline error flag
module bsg_sync_gray_rx #(
    parameter int width_p       = 8,
    parameter int sync_stages_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] ptr_o,
    output logic [width_p-1:0] delta_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic               err_o
);
    logic [width_p-1:0]   s_q [sync_stages_p];
    logic [width_p-1:0]   g, diff, prev_q, ptr_q, ptr_d, cons_q, cons_d;
    logic [sync_stages_p:0] vld_q;
    logic                 bad, err_q, err_d;

    assign g       = s_q[sync_stages_p-1];
    assign diff    = g ^ prev_q;
    assign delta_o = ptr_q - cons_q;
    assign v_o     = |delta_o;
    assign ptr_o   = ptr_q;
    assign err_o   = err_q;

    // Gray to binary decode of the last sync stage, plus the consume and error next-state.
    // vld_q marks how far post-reset samples have travelled; the check waits until prev_q
    // holds a real sample so the reset-zero to first-pointer transition is never flagged.
    always_comb begin
        ptr_d = g;
        for (int i = width_p - 2; i >= 0; i--) ptr_d[i] = ptr_d[i+1] ^ g[i];
        bad    = vld_q[sync_stages_p] && |(diff & (diff - width_p'(1)));
        cons_d = (yumi_i && v_o) ? ptr_q : cons_q;
        err_d  = err_q | bad;
    end

    // Synchronizer chain and pointer state; only s_q[0] samples the foreign-domain input.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < sync_stages_p; k++) s_q[k] <= '0;
            prev_q <= '0;
            ptr_q  <= '0;
            cons_q <= '0;
            err_q  <= 1'b0;
            vld_q  <= '0;
        end else begin
            s_q[0] <= gray_i;
            for (int k = 1; k < sync_stages_p; k++) s_q[k] <= s_q[k-1];
            prev_q <= g;
            ptr_q  <= ptr_d;
            cons_q <= cons_d;
            err_q  <= err_d;
            vld_q  <= {vld_q[sync_stages_p-1:0], 1'b1};
        end
    end
endmodule

// File: tb/tb_bsg_sync_gray_rx.sv
// tb_bsg_sync_gray_rx: randomized and directed checks of bsg_sync_gray_rx against a queue-based pointer model
module tb_bsg_sync_gray_rx;
    logic        clk = 0, rst_n = 0, ya = 0, yb = 0;
    logic [3:0]  ga = 0, ptr_a, delta_a, ba = 0, xda;
    logic [15:0] gb = 0, ptr_b, delta_b, bb = 0, xdb;
    logic        v_a, err_a, v_b, err_b;
    int          vecs = 0, miss = 0;

    logic [31:0] qa[$], qb[$];
    logic [31:0] pa, ca, pva, xa, pb, cb, pvb, xb;
    logic        ea, eb;
    int          na, nb;

    always #5 clk = ~clk;

    bsg_sync_gray_rx #(.width_p(4), .sync_stages_p(2)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .gray_i(ga), .ptr_o(ptr_a),
        .delta_o(delta_a), .v_o(v_a), .yumi_i(ya), .err_o(err_a));

    bsg_sync_gray_rx #(.width_p(16), .sync_stages_p(3)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .gray_i(gb), .ptr_o(ptr_b),
        .delta_o(delta_b), .v_o(v_b), .yumi_i(yb), .err_o(err_b));

    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b = 0;
        for (int i = 0; i < 32; i++) b ^= g >> i;
        return b;
    endfunction

    // Reference: the pointer seen by the decoder is the input sampled sync_stages_p edges earlier.
    always @(posedge clk) begin
        if (!rst_n) begin
            qa = '{32'd0, 32'd0}; pa = 0; ca = 0; pva = 0; ea = 0; na = 0;
            qb = '{32'd0, 32'd0, 32'd0}; pb = 0; cb = 0; pvb = 0; eb = 0; nb = 0;
        end else begin
            if (ya && pa != ca) ca = pa;
            xa = qa.pop_front(); qa.push_back(32'(ga));
            if (na >= 3 && $countones(xa ^ pva) > 1) ea = 1'b1;
            pva = xa; pa = g2b(xa); na++;
            if (yb && pb != cb) cb = pb;
            xb = qb.pop_front(); qb.push_back(32'(gb));
            if (nb >= 4 && $countones(xb ^ pvb) > 1) eb = 1'b1;
            pvb = xb; pb = g2b(xb); nb++;
        end
    end

    assign xda = pa[3:0] - ca[3:0];
    assign xdb = pb[15:0] - cb[15:0];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic walk_a(input logic [3:0] to, input bit eat);
        int n = int'(4'(to - ba)) + 3 + int'(eat);
        for (int i = 0; i < n; i++) begin
            if (ba != to) begin ba = ba + 4'd1; ga = ba ^ (ba >> 1); end
            ya = eat && i == n - 1;
            tick();
            ya = 0;
            if ({ptr_a, delta_a, v_a, err_a} !== {pa[3:0], xda, xda != 4'd0, ea}) begin
                miss++;
                $display("FAIL walk_a: ptr=%0d delta=%0d v=%0b err=%0b, want ptr=%0d delta=%0d v=%0b err=%0b",
                         ptr_a, delta_a, v_a, err_a, pa[3:0], xda, xda != 4'd0, ea);
            end
            vecs++;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; ga = 4'b0110; ba = 4'd4;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst_n = 1;
            tick();
            if ({ptr_a, delta_a, v_a, err_a} !== {pa[3:0], xda, xda != 4'd0, ea}) begin
                miss++;
                $display("FAIL reset[%0d]: ptr=%0d delta=%0d v=%0b err=%0b, want ptr=%0d delta=%0d v=%0b err=%0b",
                         i, ptr_a, delta_a, v_a, err_a, pa[3:0], xda, xda != 4'd0, ea);
            end
            vecs++;
        end
        vecs++;
        if (ptr_a !== 4'd4 || err_a !== 1'b0) begin
            miss++;
            $display("FAIL reset_release: ptr=%0d err=%0b, want ptr=4 err=0", ptr_a, err_a);
        end
    endtask

    task automatic test_single();
        rst_n = 0; ga = 0; ba = 0;
        tick(); tick();
        rst_n = 1;
        tick(); tick(); tick();
        ba = 4'd1; ga = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            ya = i == 4;
            tick();
            ya = 0;
            if ({ptr_a, delta_a, v_a, err_a} !== {pa[3:0], xda, xda != 4'd0, ea}) begin
                miss++;
                $display("FAIL single[%0d]: ptr=%0d delta=%0d v=%0b err=%0b, want ptr=%0d delta=%0d v=%0b err=%0b",
                         i, ptr_a, delta_a, v_a, err_a, pa[3:0], xda, xda != 4'd0, ea);
            end
            vecs++;
            if (i < 3 && ptr_a !== 4'd0) begin miss++; $display("FAIL single_early[%0d]: ptr=%0d want 0", i, ptr_a); end
            if (i == 3 && {ptr_a, delta_a, v_a} !== {4'd1, 4'd1, 1'b1}) begin
                miss++;
                $display("FAIL single_lat: ptr=%0d delta=%0d v=%0b, want 1 1 1", ptr_a, delta_a, v_a);
            end
            if (i == 4 && {delta_a, v_a} !== {4'd0, 1'b0}) begin
                miss++;
                $display("FAIL single_yumi: delta=%0d v=%0b, want 0 0", delta_a, v_a);
            end
            vecs++;
        end
    endtask

    task automatic test_wrap();
        walk_a(4'd13, 1);
        walk_a(4'd1, 0);
        vecs++;
        if (delta_a !== 4'd4) begin miss++; $display("FAIL wrap_delta: delta=%0d want 4", delta_a); end
        walk_a(4'd1, 1);
        vecs++;
        if ({delta_a, v_a} !== {4'd0, 1'b0}) begin miss++; $display("FAIL wrap_clear: delta=%0d v=%0b want 0 0", delta_a, v_a); end
    endtask

    task automatic test_simul();
        walk_a(4'd3, 1);
        walk_a(4'd5, 0);
        ba = 4'd6; ga = ba ^ (ba >> 1);
        for (int i = 1; i <= 4; i++) begin
            ya = i == 3;
            tick();
            ya = 0;
            if ({ptr_a, delta_a, v_a, err_a} !== {pa[3:0], xda, xda != 4'd0, ea}) begin
                miss++;
                $display("FAIL simul[%0d]: ptr=%0d delta=%0d v=%0b err=%0b, want ptr=%0d delta=%0d v=%0b err=%0b",
                         i, ptr_a, delta_a, v_a, err_a, pa[3:0], xda, xda != 4'd0, ea);
            end
            vecs++;
        end
        vecs++;
        if ({ptr_a, delta_a, v_a} !== {4'd6, 4'd1, 1'b1}) begin
            miss++;
            $display("FAIL simul_keep: ptr=%0d delta=%0d v=%0b, want 6 1 1", ptr_a, delta_a, v_a);
        end
        walk_a(4'd6, 1);
    endtask

    task automatic test_spurious();
        ya = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({ptr_a, delta_a, v_a, err_a} !== {pa[3:0], xda, xda != 4'd0, ea}) begin
                miss++;
                $display("FAIL spurious[%0d]: ptr=%0d delta=%0d v=%0b err=%0b, want ptr=%0d delta=%0d v=%0b err=%0b",
                         i, ptr_a, delta_a, v_a, err_a, pa[3:0], xda, xda != 4'd0, ea);
            end
            vecs++;
        end
        ya = 0;
        walk_a(4'd7, 0);
        vecs++;
        if ({ptr_a, delta_a} !== {4'd7, 4'd1}) begin
            miss++;
            $display("FAIL spurious_cons: ptr=%0d delta=%0d, want 7 1", ptr_a, delta_a);
        end
    endtask

    task automatic test_violation();
        rst_n = 0; ga = 0; ba = 0;
        tick(); tick();
        rst_n = 1;
        tick(); tick(); tick();
        ga = 4'b0011; ba = 4'd2;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) rst_n = 0;
            tick();
            if ({ptr_a, delta_a, v_a, err_a} !== {pa[3:0], xda, xda != 4'd0, ea}) begin
                miss++;
                $display("FAIL violation[%0d]: ptr=%0d delta=%0d v=%0b err=%0b, want ptr=%0d delta=%0d v=%0b err=%0b",
                         i, ptr_a, delta_a, v_a, err_a, pa[3:0], xda, xda != 4'd0, ea);
            end
            vecs++;
            if (i >= 3 && i < 8 && err_a !== 1'b1) begin miss++; $display("FAIL violation_err[%0d]: err=%0b want 1", i, err_a); end
            if (i == 8 && err_a !== 1'b0) begin miss++; $display("FAIL violation_clear: err=%0b want 0", err_a); end
            vecs++;
        end
        ga = 0; ba = 0; rst_n = 1;
        tick(); tick(); tick();
    endtask

    task automatic test_depth();
        bb = 16'd1; gb = 16'd1;
        for (int i = 1; i <= 5; i++) begin
            yb = i == 5;
            tick();
            yb = 0;
            if ({ptr_b, delta_b, v_b, err_b} !== {pb[15:0], xdb, xdb != 16'd0, eb}) begin
                miss++;
                $display("FAIL depth[%0d]: ptr=%0d delta=%0d v=%0b err=%0b, want ptr=%0d delta=%0d v=%0b err=%0b",
                         i, ptr_b, delta_b, v_b, err_b, pb[15:0], xdb, xdb != 16'd0, eb);
            end
            vecs++;
            if (i < 4 && ptr_b !== 16'd0) begin miss++; $display("FAIL depth_early[%0d]: ptr=%0d want 0", i, ptr_b); end
            if (i == 4 && {ptr_b, delta_b, v_b} !== {16'd1, 16'd1, 1'b1}) begin
                miss++;
                $display("FAIL depth_lat: ptr=%0d delta=%0d v=%0b, want 1 1 1", ptr_b, delta_b, v_b);
            end
            if (i == 5 && v_b !== 1'b0) begin miss++; $display("FAIL depth_yumi: v=%0b want 0", v_b); end
            vecs++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(1)) begin ba = ba + 4'd1; ga = ba ^ (ba >> 1); end
            if ($urandom_range(2) != 0) begin bb = bb + 16'd1; gb = bb ^ (bb >> 1); end
            ya = $urandom_range(3) == 0;
            yb = $urandom_range(4) == 0;
            rst_n = !(i % 150 == 149 && $urandom_range(1) == 1);
            tick();
            if ({ptr_a, delta_a, v_a, err_a} !== {pa[3:0], xda, xda != 4'd0, ea}) begin
                miss++;
                $display("FAIL random_a[%0d]: ptr=%0d delta=%0d v=%0b err=%0b, want ptr=%0d delta=%0d v=%0b err=%0b",
                         i, ptr_a, delta_a, v_a, err_a, pa[3:0], xda, xda != 4'd0, ea);
            end
            vecs++;
            if ({ptr_b, delta_b, v_b, err_b} !== {pb[15:0], xdb, xdb != 16'd0, eb}) begin
                miss++;
                $display("FAIL random_b[%0d]: ptr=%0d delta=%0d v=%0b err=%0b, want ptr=%0d delta=%0d v=%0b err=%0b",
                         i, ptr_b, delta_b, v_b, err_b, pb[15:0], xdb, xdb != 16'd0, eb);
            end
            vecs++;
        end
        ya = 0; yb = 0; rst_n = 1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_wrap();
        test_simul();
        test_spurious();
        test_violation();
        test_depth();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
